// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operation sequencer: opcodes,
// sequencer state encoding and the divide-by-zero result pattern.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_ROL  = 4'h6;
   localparam logic [3:0] OP_ROR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_NOR  = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_XNOR = 4'hD;
   localparam logic [3:0] OP_GT   = 4'hE;
   localparam logic [3:0] OP_EQ   = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // Reported in place of the ALU output when dividing by zero.
   localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time onto the shared combinational ALU:
// accept a request, drive registered operands for one cycle, capture the
// result (or the divide-by-zero pattern) and hold it until it is consumed.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned SEL_W  = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SEL_W-1:0]    in_op,
   input  logic [DATA_W-1:0]   in_a,
   input  logic [DATA_W-1:0]   in_b,
   input  logic                in_chain,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [SEL_W-1:0]    alu_sel,
   input  logic [2*DATA_W-1:0] alu_out,
   input  logic                alu_carry,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [2*DATA_W-1:0] res_data,
   output logic                res_carry,
   output logic                res_err,
   output logic [CNT_W-1:0]    op_count
);

   seq_state_t        state;
   // Only the low half of a result can ever be chained back in as operand A.
   logic [DATA_W-1:0] last_res;
   logic              div_by_zero;

   // Guard looks at the registered operands the ALU is currently evaluating.
   always_comb begin
      div_by_zero = (alu_sel == SEL_W'(OP_DIV)) && (alu_b == '0);
   end

   // Request/result FSM with operand, result, chaining and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;  // IDLE always advertises ready, including out of reset
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_err   <= 1'b0;
         op_count  <= '0;
         last_res  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  alu_sel  <= in_op;
                  alu_b    <= in_b;
                  alu_a    <= in_chain ? last_res : in_a;
                  in_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (div_by_zero) begin
                  res_data  <= (2*DATA_W)'(DIV0_RESULT);
                  res_carry <= 1'b0;
                  res_err   <= 1'b1;
               end else begin
                  res_data  <= alu_out;
                  res_carry <= alu_carry;
                  res_err   <= 1'b0;
               end
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               // in_ready only rises after the handoff edge, so no same-cycle accept.
               if (res_ready) begin
                  last_res  <= res_data[DATA_W-1:0];
                  op_count  <= op_count + CNT_W'(1);
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a stand-in ALU, a transaction
// model checked every cycle, and literal expectations for key scenarios.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       in_chain;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_out;
   logic       alu_carry;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic       res_err;
   logic [7:0] op_count;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .DATA_W (4),
      .SEL_W  (4),
      .CNT_W  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_chain  (in_chain),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_carry (res_carry),
      .res_err   (res_err),
      .op_count  (op_count)
   );

   // Stand-in ALU: {carry, result}. Divide by zero deliberately returns a
   // pattern the sequencer must replace.
   function automatic logic [8:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s);
      logic [4:0] t;
      logic [7:0] r;
      logic       c;
      r = 8'h00;
      c = 1'b0;
      t = 5'd0;
      case (s)
         4'h0: begin t = {1'b0, a} + {1'b0, b}; r = {3'b000, t}; c = t[4]; end
         4'h1: begin r = {4'h0, a - b}; c = (a < b); end
         4'h2: r = {4'h0, a} * {4'h0, b};
         4'h3: begin
            if (b == 4'h0) begin r = 8'h00; c = 1'b1; end
            else r = {4'h0, a / b};
         end
         4'h4: r = {4'h0, a} << b[1:0];
         4'h5: r = {4'h0, a >> b[1:0]};
         4'h8: r = {4'h0, a & b};
         4'h9: r = {4'h0, a | b};
         4'hE: r = {7'd0, a > b};
         4'hF: r = {7'd0, a == b};
         default: r = {4'h0, a ^ b};
      endcase
      return {c, r};
   endfunction

   always_comb begin
      {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);
   end

   // Transaction model: phase 0 waiting for a request, 1 operation issued,
   // 2 result offered. Expected result is computed when the request is taken.
   int         phase = 0;
   logic [3:0] m_a = 0, m_b = 0, m_sel = 0, m_last = 0;
   logic [7:0] m_res = 0, m_cnt = 0, p_res = 0;
   logic       m_c = 0, m_err = 0, m_valid = 0, p_c = 0, p_err = 0;

   always @(posedge clk) begin
      if (rst) begin
         phase = 0; m_a = 0; m_b = 0; m_sel = 0; m_last = 0;
         m_res = 0; m_c = 0; m_err = 0; m_valid = 0; m_cnt = 0;
      end else if (phase == 0) begin
         if (in_valid) begin
            m_sel = in_op;
            m_b   = in_b;
            m_a   = in_chain ? m_last : in_a;
            if (m_sel == 4'h3 && m_b == 4'h0) {p_err, p_c, p_res} = {1'b1, 1'b0, 8'hFF};
            else {p_err, p_c, p_res} = {1'b0, alu_f(m_a, m_b, m_sel)};
            phase = 1;
         end
      end else if (phase == 1) begin
         {m_err, m_c, m_res} = {p_err, p_c, p_res};
         m_valid = 1'b1;
         phase = 2;
      end else if (res_ready) begin
         m_last  = m_res[3:0];
         m_cnt   = m_cnt + 8'd1;
         m_valid = 1'b0;
         phase   = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",  in_ready,  phase == 0);
         check("res_valid", res_valid, m_valid);
         check("res_data",  res_data,  m_res);
         check("res_carry", res_carry, m_c);
         check("res_err",   res_err,   m_err);
         check("alu_a",     alu_a,     m_a);
         check("alu_b",     alu_b,     m_b);
         check("alu_sel",   alu_sel,   m_sel);
         check("op_count",  op_count,  m_cnt);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // Present one request for a single cycle; caller ensures the DUT is idle.
   task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic chain);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_chain = chain;
      tick();
      in_valid = 1'b0; in_chain = 1'b0;
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!res_valid && k < 20) begin
         tick();
         k++;
      end
      if (!res_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL res_valid_timeout: got 0 expected 1 at %0t", $time);
      end
   endtask

   task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic chain);
      issue(op, a, b, chain);
      wait_valid();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_a = 4'h0; in_b = 4'h0;
      in_chain = 1'b0; res_ready = 1'b0;
      tick(2);
      chk_en = 1'b1;
      check("reset_res_valid", res_valid, 1'b0);
      check("reset_op_count", op_count, 8'd0);
      check("reset_alu_a", alu_a, 4'h0);
      rst = 1'b0;
      tick();
      check("idle_in_ready", in_ready, 1'b1);

      // Basic add: result one cycle after the EXEC cycle, carry out of 9+8.
      res_ready = 1'b1;
      issue(4'h0, 4'd9, 4'd8, 1'b0);
      check("add_exec_no_valid", res_valid, 1'b0);
      check("add_exec_in_ready", in_ready, 1'b0);
      tick();
      check("add_res_valid", res_valid, 1'b1);
      check("add_res_data", res_data, 8'h11);
      check("add_res_carry", res_carry, 1'b1);
      check("add_res_err", res_err, 1'b0);
      tick();
      check("add_op_count", op_count, 8'd1);

      // Divide by zero, then a legal divide.
      run_op(4'h3, 4'd7, 4'd0, 1'b0);
      check("div0_data", res_data, 8'hFF);
      check("div0_err", res_err, 1'b1);
      check("div0_carry", res_carry, 1'b0);
      tick();
      run_op(4'h3, 4'd7, 4'd2, 1'b0);
      check("div_data", res_data, 8'h03);
      check("div_err", res_err, 1'b0);
      tick();

      // Chaining: 3*5 feeds operand A of the following subtract.
      run_op(4'h2, 4'd3, 4'd5, 1'b0);
      check("mul_data", res_data, 8'h0F);
      tick();
      run_op(4'h1, 4'd0, 4'd2, 1'b1);
      check("chain_alu_a", alu_a, 4'hF);
      check("chain_sub_data", res_data, 8'h0D);
      tick();

      // Backpressure with a pending request that changes while blocked.
      res_ready = 1'b0;
      in_valid = 1'b1; in_op = 4'h0; in_a = 4'd1; in_b = 4'd2; in_chain = 1'b0;
      tick(2);
      in_a = 4'd5; in_b = 4'd6;
      check("bp_data", res_data, 8'h03);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_hold_data", res_data, 8'h03);
         check("bp_hold_alu_a", alu_a, 4'd1);
      end
      res_ready = 1'b1;
      tick();
      check("bp_handoff_ready", in_ready, 1'b1);
      check("bp_handoff_count", op_count, 8'd6);
      tick();
      check("bp_next_accept_a", alu_a, 4'd5);
      check("bp_next_accept_b", alu_b, 4'd6);
      in_valid = 1'b0;
      wait_valid();
      check("bp_next_data", res_data, 8'h0B);
      tick();

      // Reset while the operation is executing.
      issue(4'h0, 4'd1, 4'd1, 1'b0);
      rst = 1'b1;
      tick();
      check("rst_mid_valid", res_valid, 1'b0);
      check("rst_mid_count", op_count, 8'd0);
      check("rst_mid_data", res_data, 8'h00);
      rst = 1'b0;
      tick(2);
      check("rst_after_valid", res_valid, 1'b0);

      // First chained op after reset sees A=0.
      run_op(4'h0, 4'd9, 4'd3, 1'b1);
      check("chain_rst_alu_a", alu_a, 4'h0);
      check("chain_rst_data", res_data, 8'h03);
      tick();

      // Counter wrap across 256 back-to-back handshakes.
      do_reset();
      in_valid = 1'b1; in_op = 4'hF; in_a = 4'd4; in_b = 4'd4; in_chain = 1'b0;
      for (int i = 0; i < 256; i++) begin
         wait_valid();
         if (i == 0) check("eq_data", res_data, 8'h01);
         tick();
         if (i == 254) check("wrap_count_255", op_count, 8'd255);
      end
      in_valid = 1'b0;
      check("wrap_count_0", op_count, 8'd0);
      tick(3);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
